mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port 256x16 program/data memory. It shares the memory between the instruction-fetch port (read-only) and the data port (read/write). It converts each port's req/ack handshake into the memory's ce/rw/addr/reg_in access sequence and captures read data. It sits between the CPU control unit and the memory instance, with one access in flight at a time.

---
 rtl/mem_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter and access sequencer for a single-port 256x16
// program/data memory. The instruction-fetch port (read-only) and the data
// port (read/write) each use a req/ack handshake. The arbiter turns a granted
// request into the memory's ce/rw/addr/reg_in sequence and captures the read
// word. Only one access is in flight at a time.
//
// Access sequence, with edge N being the IDLE edge that grants:
//   N   : load mem_addr/mem_rw/mem_wdata, raise mem_ce, busy high
//   N+1 : memory samples ce and performs the access; drop mem_ce
//   N+2 : capture mem_rdata, pulse the granted ack, busy low
// Back-to-back throughput is one access every three cycles.
//
// Configuration macro:
//   MEM_ARB_FIXED_PRIO_EN  defined   -> data port always wins a tie
//                          undefined -> round-robin on ties (default)
//
// Ports:
//   clk        system clock, all state on the rising edge
//   clr        synchronous active-low reset (shared with the memory)
//   if_req     fetch request, held until if_ack
//   if_addr    fetch address
//   if_ack     one-cycle fetch-complete pulse
//   if_data    fetched word, valid from if_ack until the next fetch ack
//   dm_req     data request, held until dm_ack
//   dm_rw      1 = read, 0 = write (same polarity as the memory rw)
//   dm_addr    data address
//   dm_wdata   write data
//   dm_ack     one-cycle data-complete pulse
//   dm_rdata   read word, updated only on a read ack
//   busy       high whenever the sequencer is not IDLE
//   mem_ce     memory chip enable
//   mem_rw     memory read/write select
//   mem_addr   memory address
//   mem_wdata  memory write data (reg_in)
//   mem_rdata  memory read data (reg_out)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  clr,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_data,

    input  logic                  dm_req,
    input  logic                  dm_rw,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ack,
    output logic [DATA_WIDTH-1:0] dm_rdata,

    output logic                  busy,

    output logic                  mem_ce,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Port identifiers used for grant and last_grant bookkeeping.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    state_e                state_q,     state_d;
    logic                  mem_ce_q,    mem_ce_d;
    logic                  mem_rw_q,    mem_rw_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_ack_q,    if_ack_d;
    logic                  dm_ack_q,    dm_ack_d;
    logic [DATA_WIDTH-1:0] if_data_q,   if_data_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q,  dm_rdata_d;
    logic                  busy_q,      busy_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q,     grant_d;

    // A port whose ack is high this cycle is still holding req from the
    // access just completed; ignoring it here stops a double grant.
    logic if_live;
    logic dm_live;
    logic pick_dm;

    assign if_live = if_req & ~if_ack_q;
    assign dm_live = dm_req & ~dm_ack_q;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Data port wins every tie; last_grant is tracked but not consulted.
    assign pick_dm = dm_live;
`else
    // Round-robin: on a tie, serve the port that was not served last.
    assign pick_dm = dm_live & (~if_live | (last_grant_q == PORT_IF));
`endif

    // Next-state and output logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        mem_ce_d     = mem_ce_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_data_d    = if_data_q;
        dm_rdata_d   = dm_rdata_q;
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (if_live || dm_live) begin
                    state_d  = ACCESS;
                    mem_ce_d = 1'b1;
                    busy_d   = 1'b1;
                    if (pick_dm) begin
                        grant_d     = PORT_DM;
                        mem_addr_d  = dm_addr;
                        mem_rw_d    = dm_rw;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        // Fetches are always reads; write data is left as is.
                        grant_d    = PORT_IF;
                        mem_addr_d = if_addr;
                        mem_rw_d   = 1'b1;
                    end
                end
            end

            ACCESS: begin
                // The memory samples ce at the edge that leaves this state.
                state_d  = RESP;
                mem_ce_d = 1'b0;
                busy_d   = 1'b1;
            end

            RESP: begin
                // mem_rdata is valid only during this cycle; capture it now.
                state_d      = IDLE;
                busy_d       = 1'b0;
                last_grant_d = grant_q;
                if (grant_q == PORT_IF) begin
                    if_ack_d  = 1'b1;
                    if_data_d = mem_rdata;
                end else begin
                    dm_ack_d = 1'b1;
                    // A write completes without disturbing the last read word.
                    if (mem_rw_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                mem_ce_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State registers. A reset in ACCESS or RESP simply abandons the access:
    // no ack is produced and every output returns to its idle value.
    always_ff @(posedge clk) begin
        if (!clr) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of every other flop.
            state_q      <= IDLE;
            mem_ce_q     <= 1'b0;
            mem_rw_q     <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_data_q    <= '0;
            dm_rdata_q   <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= PORT_DM;
            grant_q      <= PORT_IF;
        end else begin
            state_q      <= state_d;
            mem_ce_q     <= mem_ce_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_data_q    <= if_data_d;
            dm_rdata_q   <= dm_rdata_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    assign mem_ce    = mem_ce_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_data   = if_data_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter with a behavioural 256x16 single-port memory.
// Directed accesses push their hand-computed responses into a queue; a
// monitor on the falling edge pops one entry per ack and compares port and
// data. Handshake timing is checked inline by the stimulus process.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          clr;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_data;
    logic          dm_req;
    logic          dm_rw;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          busy;
    logic          mem_ce;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .clr       (clr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_data   (if_data),
        .dm_req    (dm_req),
        .dm_rw     (dm_rw),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .busy      (busy),
        .mem_ce    (mem_ce),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural memory: acts at an edge where ce is high and drives its
    // output register only in the following cycle. 16'hDEAD stands in for
    // the undriven bus so a mistimed capture shows up as a wrong value.
    logic [DW-1:0] tb_mem [256];
    logic [DW-1:0] mem_out;
    logic          mem_drive;

    always @(posedge clk) begin
        mem_drive <= mem_ce;
        if (mem_ce) begin
            if (mem_rw) mem_out <= tb_mem[mem_addr];
            else        tb_mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_drive ? mem_out : 16'hDEAD;

    // Scoreboard.
    typedef struct {
        logic          is_dm;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic is_dm, input logic [DW-1:0] data);
        exp_t e;
        e.is_dm = is_dm;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack consumes one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (if_ack) begin
            if (exp_q.size() == 0) begin
                check("if_ack_unexpected", {31'd0, if_ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("if_ack_port", {31'd0, if_ack}, {31'd0, ~e.is_dm});
                check("if_data", {16'd0, if_data}, {16'd0, e.data});
            end
        end
        if (dm_ack) begin
            if (exp_q.size() == 0) begin
                check("dm_ack_unexpected", {31'd0, dm_ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("dm_ack_port", {31'd0, dm_ack}, {31'd0, e.is_dm});
                check("dm_rdata", {16'd0, dm_rdata}, {16'd0, e.data});
            end
        end
    end

    // Wait for a grant (mem_ce high) seen on a falling edge.
    task automatic wait_ce(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ce && n < 20);
        check(name, {31'd0, mem_ce}, 32'd1);
    endtask

    // Wait for the given port's ack seen on a falling edge.
    task automatic wait_ack(input logic is_dm, input string name);
        int   n = 0;
        logic seen;
        do begin
            @(negedge clk);
            n++;
            seen = is_dm ? dm_ack : if_ack;
        end while (!seen && n < 20);
        check(name, {31'd0, seen}, 32'd1);
    endtask

    // One complete access on one port, with grant-cycle checks.
    task automatic access(input logic is_dm, input logic rw, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_data);
        push(is_dm, exp_data);
        if (is_dm) begin
            dm_req = 1'b1; dm_rw = rw; dm_addr = addr; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        wait_ce("grant_ce");
        check("grant_addr", {24'd0, mem_addr}, {24'd0, addr});
        check("grant_rw", {31'd0, mem_rw}, {31'd0, (is_dm ? rw : 1'b1)});
        check("grant_busy", {31'd0, busy}, 32'd1);
        if (is_dm && !rw) check("grant_wdata", {16'd0, mem_wdata}, {16'd0, wd});
        @(negedge clk);
        check("ce_one_cycle", {31'd0, mem_ce}, 32'd0);
        wait_ack(is_dm, "ack_seen");
        check("busy_low_in_ack", {31'd0, busy}, 32'd0);
        if (is_dm) dm_req = 1'b0;
        else       if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acks;

        tb_mem[3] = 16'h3803;
        tb_mem[5] = 16'h5A5A;
        tb_mem[7] = 16'h0777;
        tb_mem[9] = 16'h9009;

        // Reset held for two cycles with a fetch already pending.
        clr = 1'b0;
        if_req = 1'b1; if_addr = 8'd3;
        dm_req = 1'b0; dm_rw = 1'b1; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
        check("rst_mem_rw", {31'd0, mem_rw}, 32'd1);
        check("rst_if_ack", {31'd0, if_ack}, 32'd0);
        check("rst_dm_ack", {31'd0, dm_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_if_data", {16'd0, if_data}, 32'd0);
        check("rst_dm_rdata", {16'd0, dm_rdata}, 32'd0);
        push(1'b0, 16'h3803);
        clr = 1'b1;
        @(negedge clk);
        check("first_grant_after_reset", {31'd0, mem_ce}, 32'd1);
        check("first_grant_addr", {24'd0, mem_addr}, 32'd3);
        check("first_grant_rw", {31'd0, mem_rw}, 32'd1);
        wait_ack(1'b0, "first_fetch_ack");
        if_req = 1'b0;

        // Single fetch, data read, write, read-back.
        access(1'b0, 1'b1, 8'd5,  16'h0000, 16'h5A5A);
        access(1'b1, 1'b1, 8'd7,  16'h0000, 16'h0777);
        access(1'b1, 1'b0, 8'd20, 16'hBEEF, 16'h0777);
        access(1'b1, 1'b1, 8'd20, 16'h0000, 16'hBEEF);

        // Masking: fetch req held through its ack cycle.
        push(1'b0, 16'h9009);
        push(1'b0, 16'h9009);
        if_req = 1'b1; if_addr = 8'd9;
        wait_ce("mask_first_grant");
        wait_ack(1'b0, "mask_first_ack");
        @(negedge clk);
        check("mask_no_regrant", {31'd0, mem_ce}, 32'd0);
        check("mask_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("regrant_after_mask", {31'd0, mem_ce}, 32'd1);
        check("regrant_addr", {24'd0, mem_addr}, 32'd9);
        wait_ack(1'b0, "mask_second_ack");
        if_req = 1'b0;

        // Contention: both ports requesting from reset.
        clr = 1'b0;
        if_req = 1'b1; if_addr = 8'd3;
        dm_req = 1'b1; dm_rw = 1'b1; dm_addr = 8'd20;
        repeat (2) @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
        push(1'b1, 16'hBEEF); push(1'b0, 16'h3803);
        push(1'b1, 16'hBEEF); push(1'b0, 16'h3803);
`else
        push(1'b0, 16'h3803); push(1'b1, 16'hBEEF);
        push(1'b0, 16'h3803); push(1'b1, 16'hBEEF);
`endif
        clr = 1'b1;
        acks = 0;
        for (int i = 0; i < 40 && acks < 4; i++) begin
            @(negedge clk);
            if (if_ack) acks++;
            if (dm_ack) acks++;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        check("contention_acks", acks, 32'd4);
        repeat (6) @(negedge clk);

        // Abort: reset during the ACCESS cycle of a data read.
        dm_req = 1'b1; dm_rw = 1'b1; dm_addr = 8'd7;
        wait_ce("abort_grant");
        clr = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        check("abort_mem_ce", {31'd0, mem_ce}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        clr = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dm_ack) acks++;
        end
        check("abort_no_ack", acks, 32'd0);
        check("abort_dm_rdata", {16'd0, dm_rdata}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
